// File: rtl/y_issue_scheduler.sv
// Shares the 4-stage Y multiply pipe between two requesters: round-robin issue, hazard
// blocking against in-flight destinations, per-requester outstanding caps, writeback routing.
module y_issue_scheduler #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_rega,
  input  logic [31:0] r0_regb,
  input  logic [4:0]  r0_srca,
  input  logic [4:0]  r0_srcb,
  input  logic [4:0]  r0_regdest,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_rega,
  input  logic [31:0] r1_regb,
  input  logic [4:0]  r1_srca,
  input  logic [4:0]  r1_srcb,
  input  logic [4:0]  r1_regdest,
  output logic [1:0]  y_functionalunit,
  output logic [31:0] y_rega,
  output logic [31:0] y_regb,
  output logic [4:0]  y_regdest,
  input  logic [4:0]  y_wb_regdest,
  input  logic        y_wb_writereg,
  input  logic [31:0] y_wb_wbvalue,
  output logic        r0_done,
  output logic        r1_done,
  output logic [4:0]  wb_regdest,
  output logic [31:0] wb_value,
  output logic        wb_overflow
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] FU_MUL  = 2'd3;

  // Stage 0 is the issue register; stages 1..4 shadow the Y0..Y3 output registers.
  logic [4:0]      st_valid_q, st_valid_d;
  logic [4:0]      st_owner_q, st_owner_d;
  logic [4:0][4:0] st_dest_q, st_dest_d;
  logic [2:0]      out0_q, out0_d;
  logic [2:0]      out1_q, out1_d;
  logic            last_grant_q, last_grant_d;
  logic [1:0]      y_fu_q, y_fu_d;
  logic [31:0]     y_rega_q, y_rega_d;
  logic [31:0]     y_regb_q, y_regb_d;
  logic [4:0]      y_regdest_q, y_regdest_d;

  logic elig0, elig1, grant0, grant1, retire0, retire1, retire_any;

  function automatic logic busy(input logic [4:0] r, input logic [4:0] vld,
                                input logic [4:0][4:0] dst);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (r != 5'd0 && vld[i] && dst[i] == r) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    elig0 = r0_valid && reset && (out0_q < MAX_CNT) &&
            !(busy(r0_srca, st_valid_q, st_dest_q) || busy(r0_srcb, st_valid_q, st_dest_q) ||
              busy(r0_regdest, st_valid_q, st_dest_q));
    elig1 = r1_valid && reset && (out1_q < MAX_CNT) &&
            !(busy(r1_srca, st_valid_q, st_dest_q) || busy(r1_srcb, st_valid_q, st_dest_q) ||
              busy(r1_regdest, st_valid_q, st_dest_q));
    // last_grant_q = 1 means r1 won last, so r0 takes the tie.
    grant0  = elig0 && (!elig1 || last_grant_q);
    grant1  = elig1 && (!elig0 || !last_grant_q);
    retire0 = reset && st_valid_q[4] && !st_owner_q[4];
    retire1 = reset && st_valid_q[4] && st_owner_q[4];

    st_valid_d = {st_valid_q[3:0], grant0 | grant1};
    st_owner_d = {st_owner_q[3:0], grant1};
    st_dest_d  = {st_dest_q[3:0], grant1 ? r1_regdest : (grant0 ? r0_regdest : 5'd0)};

    out0_d = out0_q;
    if (grant0 && !retire0)      out0_d = out0_q + 3'd1;
    else if (!grant0 && retire0) out0_d = out0_q - 3'd1;
    out1_d = out1_q;
    if (grant1 && !retire1)      out1_d = out1_q + 3'd1;
    else if (!grant1 && retire1) out1_d = out1_q - 3'd1;

    last_grant_d = last_grant_q;
    if (grant1)      last_grant_d = 1'b1;
    else if (grant0) last_grant_d = 1'b0;

    y_fu_d      = 2'd0;
    y_rega_d    = 32'd0;
    y_regb_d    = 32'd0;
    y_regdest_d = 5'd0;
    if (grant0) begin
      y_fu_d      = FU_MUL;
      y_rega_d    = r0_rega;
      y_regb_d    = r0_regb;
      y_regdest_d = r0_regdest;
    end else if (grant1) begin
      y_fu_d      = FU_MUL;
      y_rega_d    = r1_rega;
      y_regb_d    = r1_regb;
      y_regdest_d = r1_regdest;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_valid_q   <= '0;
      st_owner_q   <= '0;
      st_dest_q    <= '0;
      out0_q       <= '0;
      out1_q       <= '0;
      last_grant_q <= 1'b1;
      y_fu_q       <= '0;
      y_rega_q     <= '0;
      y_regb_q     <= '0;
      y_regdest_q  <= '0;
    end else begin
      st_valid_q   <= st_valid_d;
      st_owner_q   <= st_owner_d;
      st_dest_q    <= st_dest_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      last_grant_q <= last_grant_d;
      y_fu_q       <= y_fu_d;
      y_rega_q     <= y_rega_d;
      y_regb_q     <= y_regb_d;
      y_regdest_q  <= y_regdest_d;
    end
  end

  assign retire_any       = retire0 | retire1;
  assign r0_ready         = grant0;
  assign r1_ready         = grant1;
  assign r0_done          = retire0;
  assign r1_done          = retire1;
  assign wb_regdest       = retire_any ? y_wb_regdest : 5'd0;
  assign wb_value         = retire_any ? y_wb_wbvalue : 32'd0;
  assign wb_overflow      = retire_any && !y_wb_writereg;
  assign y_functionalunit = y_fu_q;
  assign y_rega           = y_rega_q;
  assign y_regb           = y_regb_q;
  assign y_regdest        = y_regdest_q;

endmodule

// File: tb/tb_y_issue_scheduler.sv
// Bench for y_issue_scheduler: directed scenarios then random traffic, each cycle checked
// against an in-flight-op list model plus a behavioural stand-in for the Y multiply pipe.
module tb_y_issue_scheduler;
  localparam int MAXO = 2;

  logic clock = 1'b0;
  logic reset;
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_rega, r0_regb, r1_rega, r1_regb;
  logic [4:0] r0_srca, r0_srcb, r0_regdest, r1_srca, r1_srcb, r1_regdest;
  logic [1:0] y_functionalunit;
  logic [31:0] y_rega, y_regb, y_wb_wbvalue, wb_value;
  logic [4:0] y_regdest, y_wb_regdest, wb_regdest;
  logic y_wb_writereg, r0_done, r1_done, wb_overflow;

  y_issue_scheduler #(.MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_rega(r0_rega), .r0_regb(r0_regb),
    .r0_srca(r0_srca), .r0_srcb(r0_srcb), .r0_regdest(r0_regdest),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_rega(r1_rega), .r1_regb(r1_regb),
    .r1_srca(r1_srca), .r1_srcb(r1_srcb), .r1_regdest(r1_regdest),
    .y_functionalunit(y_functionalunit), .y_rega(y_rega), .y_regb(y_regb),
    .y_regdest(y_regdest), .y_wb_regdest(y_wb_regdest), .y_wb_writereg(y_wb_writereg),
    .y_wb_wbvalue(y_wb_wbvalue), .r0_done(r0_done), .r1_done(r1_done),
    .wb_regdest(wb_regdest), .wb_value(wb_value), .wb_overflow(wb_overflow)
  );

  always #5 clock = ~clock;

  // Stand-in for the Y pipeline: four register stages carrying the full 64-bit product.
  typedef struct packed {logic [4:0] d; logic [63:0] p;} ystage_t;
  ystage_t yp0, yp1, yp2, yp3;
  always @(posedge clock) begin
    yp0 <= '{d: y_regdest, p: {32'd0, y_rega} * {32'd0, y_regb}};
    yp1 <= yp0;
    yp2 <= yp1;
    yp3 <= yp2;
  end
  assign y_wb_regdest  = yp3.d;
  assign y_wb_wbvalue  = yp3.p[31:0];
  assign y_wb_writereg = (yp3.p[63:32] == 32'd0);

  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [4:0] sa; logic [4:0] sb; logic [4:0] d;} req_t;
  typedef struct {int ic; int own; logic [4:0] d; logic [63:0] p;} op_t;

  req_t rq0[$], rq1[$];
  op_t  fl[$];
  bit   en0 = 1'b1, en1 = 1'b1;
  int   cyc = 0, errors = 0, checks = 0;
  int   last_g = 1;
  bit   pv = 1'b0;
  logic [31:0] pa = '0, pb = '0;
  logic [4:0]  pd = '0;

  function automatic bit dep(input logic [4:0] d, input req_t r);
    return d != 5'd0 && (d == r.sa || d == r.sb || d == r.d);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive heads, predict from the in-flight list, check, commit, advance.
  task automatic tick();
    req_t h0, h1;
    int cnt0, cnt1, gnt;
    bit hz0, hz1, e0, e1, rt;
    op_t ro;
    h0 = (rq0.size() > 0) ? rq0[0] : '0;
    h1 = (rq1.size() > 0) ? rq1[0] : '0;
    r0_valid = en0 && rq0.size() > 0;
    r1_valid = en1 && rq1.size() > 0;
    r0_rega = h0.a; r0_regb = h0.b; r0_srca = h0.sa; r0_srcb = h0.sb; r0_regdest = h0.d;
    r1_rega = h1.a; r1_regb = h1.b; r1_srca = h1.sa; r1_srcb = h1.sb; r1_regdest = h1.d;
    #1;
    cnt0 = 0; cnt1 = 0; hz0 = 0; hz1 = 0; rt = 0; ro = '{0, 0, 5'd0, 64'd0};
    foreach (fl[i]) begin
      if (fl[i].ic < cyc && cyc <= fl[i].ic + 5) begin
        if (fl[i].own == 0) cnt0++; else cnt1++;
        if (dep(fl[i].d, h0)) hz0 = 1;
        if (dep(fl[i].d, h1)) hz1 = 1;
        if (fl[i].ic + 5 == cyc) begin rt = 1; ro = fl[i]; end
      end
    end
    e0 = reset && r0_valid && cnt0 < MAXO && !hz0;
    e1 = reset && r1_valid && cnt1 < MAXO && !hz1;
    gnt = -1;
    if (e0 && e1) gnt = 1 - last_g;
    else if (e0)  gnt = 0;
    else if (e1)  gnt = 1;
    rt = rt && reset;
    chk("r0_ready", r0_ready, gnt == 0);
    chk("r1_ready", r1_ready, gnt == 1);
    chk("r0_done", r0_done, rt && ro.own == 0);
    chk("r1_done", r1_done, rt && ro.own == 1);
    chk("wb_regdest", wb_regdest, rt ? ro.d : 5'd0);
    chk("wb_value", wb_value, rt ? ro.p[31:0] : 32'd0);
    chk("wb_overflow", wb_overflow, rt && ro.p[63:32] != 32'd0);
    chk("y_functionalunit", y_functionalunit, pv ? 2'd3 : 2'd0);
    chk("y_rega", y_rega, pv ? pa : 32'd0);
    chk("y_regb", y_regb, pv ? pb : 32'd0);
    chk("y_regdest", y_regdest, pv ? pd : 5'd0);
    pv = 0; pa = '0; pb = '0; pd = '0;
    if (!reset) begin
      fl.delete();
      last_g = 1;
    end else if (gnt >= 0) begin
      req_t h;
      h = (gnt == 0) ? h0 : h1;
      fl.push_back('{cyc, gnt, h.d, {32'd0, h.a} * {32'd0, h.b}});
      last_g = gnt;
      pv = 1; pa = h.a; pb = h.b; pd = h.d;
      if (gnt == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
    end
    for (int i = fl.size() - 1; i >= 0; i--) if (fl[i].ic + 5 <= cyc) fl.delete(i);
    cyc++;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic req_t mk(input logic [31:0] a, b, input logic [4:0] sa, sb, d);
    return '{a: a, b: b, sa: sa, sb: sb, d: d};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    r0_valid = 0; r1_valid = 0;
    @(negedge clock);
    run(3);
    reset = 1'b1;

    // single op: 6*7 to dest 5
    rq0.push_back(mk(32'd6, 32'd7, 5'd0, 5'd0, 5'd5));
    run(8);

    // tie: distinct dests 1..8, no shared sources
    for (int i = 0; i < 4; i++) begin
      rq0.push_back(mk(32'(i + 1), 32'd3, 5'd0, 5'd0, 5'(2 * i + 1)));
      rq1.push_back(mk(32'(i + 9), 32'd5, 5'd0, 5'd0, 5'(2 * i + 2)));
    end
    run(20);

    // RAW: r1 reads r3 while r0's write to r3 is in flight
    rq0.push_back(mk(32'd2, 32'd2, 5'd0, 5'd0, 5'd3));
    tick();
    rq1.push_back(mk(32'd4, 32'd4, 5'd3, 5'd0, 5'd4));
    run(10);

    // register 0 never hazards
    rq0.push_back(mk(32'd9, 32'd9, 5'd0, 5'd0, 5'd0));
    tick();
    rq1.push_back(mk(32'd1, 32'd1, 5'd0, 5'd0, 5'd9));
    run(8);

    // cap: three independent ops from r0
    rq0.push_back(mk(32'd1, 32'd2, 5'd0, 5'd0, 5'd10));
    rq0.push_back(mk(32'd3, 32'd4, 5'd0, 5'd0, 5'd11));
    rq0.push_back(mk(32'd5, 32'd6, 5'd0, 5'd0, 5'd12));
    run(14);

    // overflow, then two back-to-back ops show the counter drained
    rq0.push_back(mk(32'h10000, 32'h10000, 5'd0, 5'd0, 5'd13));
    run(8);
    rq0.push_back(mk(32'd7, 32'd7, 5'd0, 5'd0, 5'd14));
    rq0.push_back(mk(32'd8, 32'd8, 5'd0, 5'd0, 5'd15));
    run(9);

    // reset mid-op
    rq0.push_back(mk(32'd11, 32'd12, 5'd0, 5'd0, 5'd16));
    run(2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rq0.push_back(mk(32'd13, 32'd14, 5'd0, 5'd0, 5'd17));
    run(9);

    // random traffic with small register space to provoke hazards
    for (int c = 0; c < 350; c++) begin
      if (rq0.size() < 2 && $urandom_range(0, 2) == 0)
        rq0.push_back(mk(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                         ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
      if (rq1.size() < 2 && $urandom_range(0, 2) == 0)
        rq1.push_back(mk(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                         ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
      en0 = $urandom_range(0, 4) != 0;
      en1 = $urandom_range(0, 4) != 0;
      reset = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset = 1'b1; en0 = 1'b1; en1 = 1'b1;
    run(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
